// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/arith/multiply results plus an iterative
// 32-step shift-subtract divider that stalls the pipeline until its quotient is ready.
module ex_stage #(
  parameter int unsigned DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        flush_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  localparam logic [7:0] OpNop   = 8'h00;
  localparam logic [7:0] OpOr    = 8'h25;
  localparam logic [7:0] OpAnd   = 8'h24;
  localparam logic [7:0] OpXor   = 8'h26;
  localparam logic [7:0] OpNor   = 8'h27;
  localparam logic [7:0] OpSll   = 8'h7C;
  localparam logic [7:0] OpSrl   = 8'h02;
  localparam logic [7:0] OpSra   = 8'h03;
  localparam logic [7:0] OpAddu  = 8'h21;
  localparam logic [7:0] OpSubu  = 8'h23;
  localparam logic [7:0] OpSlt   = 8'h2A;
  localparam logic [7:0] OpMult  = 8'h18;
  localparam logic [7:0] OpMultu = 8'h19;
  localparam logic [7:0] OpDiv   = 8'h1A;
  localparam logic [7:0] OpDivu  = 8'h1B;

  localparam logic [2:0] SelLogic = 3'd1;
  localparam logic [2:0] SelShift = 3'd2;
  localparam logic [2:0] SelArith = 3'd3;

  localparam logic [4:0] LastStep = 5'(DIV_STEPS - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

  div_state_e  r_state, w_state_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_quot;
  logic [31:0] r_rem;
  logic [31:0] r_divisor;
  logic        r_neg_q;
  logic        r_neg_r;

  logic [31:0] w_logic, w_shift, w_arith, w_wdata;
  logic [63:0] w_prod_s, w_prod_u;
  logic        w_div_op, w_div_signed, w_mul_op, w_stall;
  logic        w_a_neg, w_b_neg;
  logic [31:0] w_abs_a, w_abs_b;
  logic [32:0] w_rem_sh, w_diff;

  always_comb begin
    w_logic = '0;
    case (aluop_i)
      OpOr:    w_logic = reg1_i | reg2_i;
      OpAnd:   w_logic = reg1_i & reg2_i;
      OpXor:   w_logic = reg1_i ^ reg2_i;
      OpNor:   w_logic = ~(reg1_i | reg2_i);
      default: w_logic = '0;
    endcase
  end

  always_comb begin
    w_shift = '0;
    case (aluop_i)
      OpSll:   w_shift = reg2_i << reg1_i[4:0];
      OpSrl:   w_shift = reg2_i >> reg1_i[4:0];
      OpSra:   w_shift = $signed(reg2_i) >>> reg1_i[4:0];
      default: w_shift = '0;
    endcase
  end

  always_comb begin
    w_arith = '0;
    case (aluop_i)
      OpAddu:  w_arith = reg1_i + reg2_i;
      OpSubu:  w_arith = reg1_i - reg2_i;
      OpSlt:   w_arith = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
      default: w_arith = '0;
    endcase
  end

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign w_prod_s = {{32{reg1_i[31]}}, reg1_i} * {{32{reg2_i[31]}}, reg2_i};
  assign w_prod_u = {32'd0, reg1_i} * {32'd0, reg2_i};
  assign w_mul_op = (aluop_i == OpMult) || (aluop_i == OpMultu);

  assign w_div_op     = (aluop_i == OpDiv) || (aluop_i == OpDivu);
  assign w_div_signed = (aluop_i == OpDiv);
  assign w_a_neg      = w_div_signed & reg1_i[31];
  assign w_b_neg      = w_div_signed & reg2_i[31];
  assign w_abs_a      = w_a_neg ? (~reg1_i + 32'd1) : reg1_i;
  assign w_abs_b      = w_b_neg ? (~reg2_i + 32'd1) : reg2_i;

  // Restoring step: rem_sh < 2*divisor, so a non-negative difference always fits 32 bits.
  assign w_rem_sh = {r_rem, r_quot[31]};
  assign w_diff   = w_rem_sh - {1'b0, r_divisor};

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    if (flush_i) begin
      w_state_next = StIdle;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_div_op) begin
            w_stall      = 1'b1;
            w_state_next = (reg2_i == '0) ? StDone : StBusy;
          end
        end
        StBusy: begin
          w_stall = 1'b1;
          if (r_cnt == LastStep) w_state_next = StDone;
        end
        StDone:  w_state_next = StIdle;
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StIdle && w_div_op && !flush_i) begin
        r_cnt <= '0;
        if (reg2_i == '0) begin
          r_quot  <= 32'hFFFF_FFFF;
          r_rem   <= reg1_i;
          r_neg_q <= 1'b0;
          r_neg_r <= 1'b0;
        end else begin
          r_quot    <= w_abs_a;
          r_rem     <= '0;
          r_divisor <= w_abs_b;
          r_neg_q   <= w_a_neg ^ w_b_neg;
          r_neg_r   <= w_a_neg;
        end
      end else if (r_state == StBusy && !flush_i) begin
        r_cnt  <= r_cnt + 5'd1;
        r_quot <= {r_quot[30:0], ~w_diff[32]};
        r_rem  <= w_diff[32] ? w_rem_sh[31:0] : w_diff[31:0];
      end
    end
  end

  always_comb begin
    w_wdata = '0;
    case (alusel_i)
      SelLogic: w_wdata = w_logic;
      SelShift: w_wdata = w_shift;
      SelArith: w_wdata = w_arith;
      default:  w_wdata = '0;
    endcase
  end

  always_comb begin
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    whilo_o    = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    stallreq_o = 1'b0;
    if (!rst) begin
      wd_o       = wd_i;
      wreg_o     = wreg_i;
      stallreq_o = w_stall;
      if (r_state == StIdle && !w_div_op) wdata_o = w_wdata;
      if (!flush_i) begin
        if (r_state == StDone) begin
          whilo_o = 1'b1;
          lo_o    = r_neg_q ? (~r_quot + 32'd1) : r_quot;
          hi_o    = r_neg_r ? (~r_rem + 32'd1) : r_rem;
        end else if (r_state == StIdle && w_mul_op) begin
          whilo_o = 1'b1;
          {hi_o, lo_o} = (aluop_i == OpMult) ? w_prod_s : w_prod_u;
        end
      end
    end
  end

  logic w_unused;
  assign w_unused = (aluop_i == OpNop);

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU classes, multiply, divider latency,
// sign fix, divide-by-zero, back-to-back divides, flush and reset mid-divide.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [31:0] reg1, reg2;
  logic [4:0]  wd;
  logic        wreg, flush;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, stallreq_o;
  logic [31:0] wdata_o, hi_o, lo_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  ex_stage dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop),
    .alusel_i   (alusel),
    .reg1_i     (reg1),
    .reg2_i     (reg2),
    .wd_i       (wd),
    .wreg_i     (wreg),
    .flush_i    (flush),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .whilo_o    (whilo_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .stallreq_o (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b);
    aluop  = op;
    alusel = sel;
    reg1   = a;
    reg2   = b;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; wd = 5'd9; wreg = 1'b1;
    drive(8'h25, 3'd1, 32'h0000_F0F0, 32'h0000_0F0F);
    @(negedge clk); @(negedge clk); #1;
    total++;
    if ({wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got wd=%h wreg=%b wdata=%h whilo=%b hi=%h lo=%h stall=%b want all 0",
               wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o);
    end
    @(negedge clk); rst = 1'b0; #1;
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    wd = 5'd17; wreg = 1'b1;
    drive(8'h25, 3'd1, 32'h0000_F0F0, 32'h0000_0F0F);
    #1;
    total++;
    if (wdata_o !== 32'h0000_FFFF) begin
      bad++; $display("FAIL or_basic: got %h want 0000ffff", wdata_o);
    end
    total++;
    if (wd_o !== 5'd17 || wreg_o !== 1'b1 || stallreq_o !== 1'b0) begin
      bad++; $display("FAIL or_passthru: got wd=%0d wreg=%b stall=%b want 17 1 0",
                      wd_o, wreg_o, stallreq_o);
    end
    // Unknown aluop: wdata 0 but wreg still follows wreg_i
    drive(8'h55, 3'd1, 32'hFFFF_FFFF, 32'h1234_5678);
    #1;
    total++;
    if (wdata_o !== 32'd0 || wreg_o !== 1'b1) begin
      bad++; $display("FAIL unknown_op: got wdata=%h wreg=%b want 0 1", wdata_o, wreg_o);
    end
    wreg = 1'b0;
  endtask

  task automatic test_alu();
    vec_t v[$];
    v.push_back('{8'h25, 3'd1, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF});
    v.push_back('{8'h24, 3'd1, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00});
    v.push_back('{8'h26, 3'd1, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F});
    v.push_back('{8'h27, 3'd1, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF});
    v.push_back('{8'h03, 3'd2, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000});
    v.push_back('{8'h7C, 3'd2, 32'h0000_001F, 32'h0000_0001, 32'h8000_0000});
    v.push_back('{8'h02, 3'd2, 32'h0000_0004, 32'h8000_0000, 32'h0800_0000});
    v.push_back('{8'h03, 3'd2, 32'hFFFF_FFE0, 32'h1234_5678, 32'h1234_5678});
    v.push_back('{8'h2A, 3'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001});
    v.push_back('{8'h2A, 3'd3, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000});
    v.push_back('{8'h21, 3'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000});
    v.push_back('{8'h23, 3'd3, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF});
    v.push_back('{8'h21, 3'd3, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C});
    v.push_back('{8'h25, 3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000});
    v.push_back('{8'h25, 3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000});
    v.push_back('{8'h21, 3'd1, 32'h0000_0005, 32'h0000_0007, 32'h0000_0000});
    foreach (v[i]) begin
      @(negedge clk);
      drive(v[i].op, v[i].sel, v[i].a, v[i].b);
      #1;
      total++;
      if (wdata_o !== v[i].exp || stallreq_o !== 1'b0 || whilo_o !== 1'b0) begin
        bad++;
        $display("FAIL alu_vec%0d op=%h: got wdata=%h stall=%b whilo=%b want %h 0 0",
                 i, v[i].op, wdata_o, stallreq_o, whilo_o, v[i].exp);
      end
    end
  endtask

  task automatic test_mult();
    logic [7:0]  ops [3] = '{8'h18, 8'h19, 8'h18};
    logic [31:0] as  [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] bs  [3] = '{32'h0000_0003, 32'h0000_0002, 32'h8000_0000};
    logic [31:0] ehi [3] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h4000_0000};
    logic [31:0] elo [3] = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'h0000_0000};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(ops[i], 3'd4, as[i], bs[i]);
      #1;
      total++;
      if (hi_o !== ehi[i] || lo_o !== elo[i] || whilo_o !== 1'b1 || stallreq_o !== 1'b0) begin
        bad++;
        $display("FAIL mult%0d: got hi=%h lo=%h whilo=%b stall=%b want %h %h 1 0",
                 i, hi_o, lo_o, whilo_o, stallreq_o, ehi[i], elo[i]);
      end
    end
    @(negedge clk); drive(8'h00, 3'd0, 32'd0, 32'd0);
  endtask

  task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_stall, input logic [31:0] exp_q,
                         input logic [31:0] exp_r, input bit end_nop);
    int  n;
    bit  done;
    n = 0; done = 1'b0;
    @(negedge clk);
    drive(op, 3'd4, a, b);
    for (int i = 0; i < 100 && !done; i++) begin
      #1;
      if (!stallreq_o) done = 1'b1;
      else begin
        n++;
        @(negedge clk);
      end
    end
    total++;
    if (!done) begin
      bad++; $display("FAIL div_timeout op=%h a=%h b=%h: stall still high after 100 cycles", op, a, b);
    end
    total++;
    if (n !== exp_stall) begin
      bad++; $display("FAIL div_stall_cycles a=%h b=%h: got %0d want %0d", a, b, n, exp_stall);
    end
    total++;
    if (whilo_o !== 1'b1 || lo_o !== exp_q || hi_o !== exp_r || wdata_o !== 32'd0) begin
      bad++;
      $display("FAIL div_result op=%h a=%h b=%h: got whilo=%b lo=%h hi=%h wdata=%h want 1 %h %h 0",
               op, a, b, whilo_o, lo_o, hi_o, wdata_o, exp_q, exp_r);
    end
    if (end_nop) begin
      @(negedge clk);
      drive(8'h00, 3'd0, 32'd0, 32'd0);
      #1;
      total++;
      if (whilo_o !== 1'b0 || stallreq_o !== 1'b0) begin
        bad++; $display("FAIL div_after: got whilo=%b stall=%b want 0 0", whilo_o, stallreq_o);
      end
    end
  endtask

  task automatic test_div();
    run_div(8'h1A, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1);
    run_div(8'h1B, 32'hFFFF_FFFF, 32'h0000_0010, 33, 32'h0FFF_FFFF, 32'h0000_000F, 1'b1);
    run_div(8'h1A, 32'h0000_0007, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'h0000_0001, 1'b1);
    run_div(8'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'h0000_0000, 1'b1);
    run_div(8'h1B, 32'h0000_1234, 32'h0000_0000, 1, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_div(8'h1B, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0);
    run_div(8'h1A, 32'hFFFF_FF9C, 32'd7, 33, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b1);
  endtask

  task automatic test_flush();
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    drive(8'h1A, 3'd4, 32'd100, 32'd3);
    repeat (11) @(negedge clk);
    #1;
    total++;
    if (stallreq_o !== 1'b1) begin
      bad++; $display("FAIL flush_busy: got stall=%b want 1", stallreq_o);
    end
    flush = 1'b1;
    #1;
    total++;
    if (stallreq_o !== 1'b0 || whilo_o !== 1'b0) begin
      bad++; $display("FAIL flush_cycle: got stall=%b whilo=%b want 0 0", stallreq_o, whilo_o);
    end
    @(negedge clk);
    flush = 1'b0;
    drive(8'h00, 3'd0, 32'd0, 32'd0);
    for (int i = 0; i < 40; i++) begin
      #1;
      if (whilo_o || stallreq_o) seen = 1'b1;
      @(negedge clk);
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL flush_discard: got whilo/stall activity=1 want 0");
    end
    run_div(8'h1B, 32'd50, 32'd5, 33, 32'd10, 32'd0, 1'b1);
  endtask

  task automatic test_reset_mid_div();
    @(negedge clk);
    wd = 5'd3; wreg = 1'b1;
    drive(8'h1A, 3'd4, 32'd1000, 32'd9);
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    total++;
    if ({wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o} !== '0) begin
      bad++;
      $display("FAIL reset_mid_div: got wd=%h wreg=%b wdata=%h whilo=%b hi=%h lo=%h stall=%b want all 0",
               wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o);
    end
    rst = 1'b0; wreg = 1'b0; wd = 5'd0;
    drive(8'h00, 3'd0, 32'd0, 32'd0);
    run_div(8'h1A, 32'd1000, 32'd9, 33, 32'd111, 32'd1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_alu();
    test_mult();
    test_div();
    test_back_to_back();
    test_flush();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
